if_fetch_unit: RTL

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues requests over a grant/response instruction-memory interface.
- Delivers pc_o/instr_o into IF/ID every non-stalled cycle: either a real fetched instruction or a NOP bubble.
- Honours hazard-unit stalls via a one-entry skid buffer, and branch/jump redirects by discarding in-flight responses.

---
 rtl/if_fetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction-fetch stage feeding IF/ID; one outstanding imem
//            request, one-entry skid buffer for stalls, redirect squashing.
// Revision : 1.0
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_out_q, instr_out_d;
    logic        valid_out_q, valid_out_d;

    logic [31:0] w_pc_inc;
    logic        w_b2b_req;

    assign w_pc_inc = pc_q + 32'd4;

    // A response being consumed in WAIT lets the next request go out in the same cycle.
    assign w_b2b_req = (state_q == S_WAIT) && imem_rvalid_i && !drop_q
                       && !stall_i && !redirect_i;

    assign imem_req_o  = (state_q == S_FETCH) || w_b2b_req;
    assign imem_addr_o = (w_b2b_req ? w_pc_inc : pc_q) & C_ALIGN_MASK;

    assign pc_o          = pc_out_q;
    assign instr_o       = instr_out_q;
    assign instr_valid_o = valid_out_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        pc_out_d     = pc_out_q;
        instr_out_d  = stall_i ? instr_out_q : NOP_INSTR;
        valid_out_d  = stall_i ? valid_out_q : 1'b0;

        if (redirect_i) begin
            pc_d         = redirect_pc_i & C_ALIGN_MASK;
            instr_out_d  = NOP_INSTR;
            valid_out_d  = 1'b0;
            skid_pc_d    = 32'd0;
            skid_instr_d = NOP_INSTR;
            drop_d       = 1'b0;
            state_d      = S_FETCH;
            // A request that is (or becomes) outstanding must have its response squashed.
            if ((state_q == S_FETCH && imem_gnt_i) ||
                (state_q == S_WAIT && !imem_rvalid_i)) begin
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_gnt_i) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_FETCH;
                        end else if (!stall_i) begin
                            pc_out_d    = pc_q;
                            instr_out_d = imem_rdata_i;
                            valid_out_d = 1'b1;
                            pc_d        = w_pc_inc;
                            state_d     = imem_gnt_i ? S_WAIT : S_FETCH;
                        end else begin
                            skid_pc_d    = pc_q;
                            skid_instr_d = imem_rdata_i;
                            pc_d         = w_pc_inc;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        pc_out_d    = skid_pc_q;
                        instr_out_d = skid_instr_q;
                        valid_out_d = 1'b1;
                        state_d     = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= NOP_INSTR;
            pc_out_q     <= 32'd0;
            instr_out_q  <= NOP_INSTR;
            valid_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            pc_out_q     <= pc_out_d;
            instr_out_q  <= instr_out_d;
            valid_out_q  <= valid_out_d;
        end
    end

endmodule
`default_nettype wire
